// File: rtl/pkt_rx_framer.sv
// Serial packet framer: hunts for a sync byte, collects a fixed-length payload plus an
// optional additive checksum from the uart byte stream, and publishes good packets.
module pkt_rx_framer #(
    parameter int         CLK_FREQ       = 50000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         PAYLOAD_BYTES  = 3,
    parameter int         CHECKSUM_EN    = 1,
    parameter int         TIMEOUT_CYCLES = CLK_FREQ / 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_avail,
    output logic                       rx_ack,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       pkt_valid,
    output logic                       cksum_err,
    output logic                       timeout_err,
    output logic [15:0]                pkt_count,
    output logic [15:0]                err_count
);

    localparam logic [3:0]  PB_IDX   = 4'(PAYLOAD_BYTES);
    localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_BYTES + CHECKSUM_EN);
    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {HUNT, HUNT_ACK, RECV, RECV_ACK, CHECK} state_t;

    state_t                     state;
    state_t                     ret_state;
    logic [3:0]                 idx;
    logic [7:0]                 sum;
    logic [23:0]                tcnt;
    logic [8*PAYLOAD_BYTES-1:0] shadow;
    logic [7:0]                 cksum_byte;
    logic                       accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept = (state == RECV) && rx_avail;

    // Data capture: shadow slots and checksum byte carry no reset, they are
    // always rewritten before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (idx == 4'(i)) shadow[i*8 +: 8] <= rx_data;
            end
            if (idx >= PB_IDX) cksum_byte <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            ret_state   <= HUNT;
            idx         <= '0;
            sum         <= '0;
            tcnt        <= '0;
            rx_ack      <= 1'b0;
            pkt_valid   <= 1'b0;
            cksum_err   <= 1'b0;
            timeout_err <= 1'b0;
            payload     <= '0;
            pkt_count   <= '0;
            err_count   <= '0;
        end else begin
            rx_ack      <= 1'b0;
            pkt_valid   <= 1'b0;
            cksum_err   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                HUNT: begin
                    tcnt <= '0;
                    if (rx_avail) begin
                        rx_ack <= 1'b1;
                        state  <= HUNT_ACK;
                        if (rx_data == SYNC_BYTE) begin
                            idx       <= '0;
                            sum       <= '0;
                            ret_state <= RECV;
                        end else begin
                            ret_state <= HUNT;
                        end
                    end
                end
                HUNT_ACK: begin
                    tcnt <= '0;
                    if (!rx_avail) state <= ret_state;
                end
                RECV: begin
                    // A byte arriving on the expiry cycle is taken; accept beats timeout.
                    if (rx_avail) begin
                        rx_ack    <= 1'b1;
                        tcnt      <= '0;
                        idx       <= idx + 4'd1;
                        ret_state <= (idx + 4'd1 < LAST_IDX) ? RECV : CHECK;
                        state     <= RECV_ACK;
                        if (idx < PB_IDX) sum <= sum + rx_data;
                    end else if (tcnt == TO_LAST) begin
                        tcnt        <= '0;
                        timeout_err <= 1'b1;
                        err_count   <= sat_inc(err_count);
                        state       <= HUNT;
                    end else begin
                        tcnt <= tcnt + 24'd1;
                    end
                end
                RECV_ACK: begin
                    if (tcnt == TO_LAST) begin
                        // Park in HUNT_ACK if the byte is still up so it is not acked twice.
                        tcnt        <= '0;
                        timeout_err <= 1'b1;
                        err_count   <= sat_inc(err_count);
                        ret_state   <= HUNT;
                        state       <= rx_avail ? HUNT_ACK : HUNT;
                    end else begin
                        tcnt <= tcnt + 24'd1;
                        if (!rx_avail) state <= ret_state;
                    end
                end
                CHECK: begin
                    tcnt  <= '0;
                    state <= HUNT;
                    if ((CHECKSUM_EN == 0) || (cksum_byte == sum)) begin
                        payload   <= shadow;
                        pkt_valid <= 1'b1;
                        pkt_count <= sat_inc(pkt_count);
                    end else begin
                        cksum_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/pkt_rx_framer.md
# pkt_rx_framer

Parametrised serial packet framer; the successor to the fixed 3-byte mouse receiver. Consumes the byte stream of the existing `uart` core (`rx_data`/`rx_avail`/`rx_ack`) and hunts for a sync byte. It then collects a configurable number of payload bytes, optionally verifies a trailing checksum, and publishes the payload as one wide register with a single-cycle valid strobe. Also provides inter-byte timeout, error strobes and saturating packet/error counters for the Paint input path and debug LEDs.

## Interface
- `CLK_FREQ`, default 50000000: clock frequency in Hz; only used for the default timeout.
- `SYNC_BYTE`, default 8'hAA: packet start marker.
- `PAYLOAD_BYTES`, default 3: payload length; legal range 1..8.
- `CHECKSUM_EN`, default 1: 1 means one checksum byte follows the payload; 0 means none.
- `TIMEOUT_CYCLES`, default CLK_FREQ/10: inter-byte timeout in clocks; must be ≥ 2 and < 2^24.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the uart core.
- `rx_avail`  in  1  byte-available flag from the uart core; level, held until acknowledged.
- `rx_ack`  out  1  one-cycle acknowledge to the uart core.
- `payload`  out  8*PAYLOAD_BYTES  last good packet; byte 0 (first after sync) is in bits [7:0].
- `pkt_valid`  out  1  one-cycle strobe; `payload` was updated on this cycle.
- `cksum_err`  out  1  one-cycle strobe; checksum mismatch.
- `timeout_err`  out  1  one-cycle strobe; inter-byte timeout.
- `pkt_count`  out  16  good packets received; saturates at 16'hFFFF.
- `err_count`  out  16  checksum plus timeout errors; saturates at 16'hFFFF.

## Operation
- States: HUNT, HUNT_ACK, RECV, RECV_ACK, CHECK.
- **HUNT**
  - `rx_avail`=1: pulse `rx_ack` and discard the byte.
  - Byte == SYNC_BYTE: go to HUNT_ACK, clear the byte index and the running sum.
  - Otherwise: go to HUNT_ACK as well, with a return target of HUNT.
- **HUNT_ACK / RECV_ACK**
  - Wait for `rx_avail`=0, then go to the return target.
  - Each byte is acknowledged exactly once; no new byte is accepted while `rx_avail` is still high from the previous one.
- **RECV**
  - On `rx_avail`=1: capture the byte and pulse `rx_ack`.
  - Index < PAYLOAD_BYTES: store the byte in shadow slot[index] and add it to the 8-bit running sum (mod 256).
  - Otherwise the byte is the checksum byte and is latched.
  - Increment the index and go to RECV_ACK.
  - After RECV_ACK, return to RECV while index < PAYLOAD_BYTES + CHECKSUM_EN; otherwise go to CHECK.
- **CHECK**, one cycle, then HUNT:
  - Pass when CHECKSUM_EN=0, or when the checksum byte == running sum.
  - Pass: copy shadow → `payload`, pulse `pkt_valid`, increment `pkt_count`.
  - Fail: pulse `cksum_err`, increment `err_count`; `payload` is unchanged.
- SYNC_BYTE values inside the payload or checksum are data; there is no mid-packet resync.
- **Timeout**
  - The 24-bit counter runs in RECV and RECV_ACK and clears on every byte accept and in HUNT/HUNT_ACK.
  - Counter reaching TIMEOUT_CYCLES-1: next state HUNT, pulse `timeout_err`, increment `err_count`, discard the shadow.
  - A byte accept in the same cycle as expiry wins: the byte is taken and there is no timeout.
  - Expiry in RECV_ACK while `rx_avail` is still high goes to HUNT_ACK, so the stale byte is not re-acknowledged.
- Counters saturate; they do not wrap.
- `cksum_err` and `timeout_err` are never asserted in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `rx_ack`, `pkt_valid`, `cksum_err`, `timeout_err` = 0.
  - `payload` = 0, `pkt_count` = 0, `err_count` = 0.
  - State = HUNT; index, sum and timeout counter = 0.
- Reset asserted mid-packet aborts immediately; no strobe is produced for the partial packet.
- `rx_ack` goes high the cycle after `rx_avail`=1 is sampled in HUNT/RECV, for exactly 1 cycle.
- Latency: the edge that samples `rx_avail`=0 after the final byte enters CHECK; the next edge asserts `pkt_valid` or `cksum_err` together with the updated `payload` and counters.
- `payload` is stable between `pkt_valid` strobes.
- Minimum packet period: 2 cycles per byte plus 1 (CHECK) plus the HUNT cycle.

## Test plan
- Defaults; send AA 01 05 FB 01:
  - `pkt_valid` for 1 cycle; `payload`=24'h FB0501; `pkt_count`=1.
  - Exactly one `rx_ack` per byte (5 total).
- Send AA 01 05 FB 02:
  - `cksum_err` for 1 cycle; `payload` still holds the prior value; `err_count`=1; no `pkt_valid`.
- Send 00 37 AA 02 03 04 09:
  - 00 and 37 are acknowledged and discarded; `payload`=24'h 040302 valid.
- Send AA 01, then silence; TIMEOUT_CYCLES=1000:
  - `timeout_err` about 1000 cycles after the last accept; state HUNT.
  - The following AA 00 00 00 00 is accepted.
- PAYLOAD_BYTES=1, CHECKSUM_EN=0; send AA AA:
  - `payload`=8'hAA valid (sync value treated as data).
- Assert `reset` one cycle after the second payload byte is accepted:
  - All outputs return to 0.
  - A subsequent full packet is received correctly.
